// File: rtl/ram8x8_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram8x8_sync : single-port 8x8 synchronous RAM with registered write-through |
// |               read data; optional per-word even parity (RAM_PARITY_EN).     |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module ram8x8_sync #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write_signal,
`ifdef RAM_PARITY_EN
    output logic [DATA_W-1:0] data_out,
    output logic              parity_err
`else
    output logic [DATA_W-1:0] data_out
`endif
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;

    // Write-through: a write updates both the array and the output register.
    always_comb begin
        mem_d  = mem_q;
        dout_d = mem_q[adr];
        if (write_signal) begin
            mem_d[adr] = data_in;
            dout_d     = data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dout_q <= '0;
        end else begin
            mem_q  <= mem_d;
            dout_q <= dout_d;
        end
    end

    assign data_out = dout_q;

`ifdef RAM_PARITY_EN
    logic [DEPTH-1:0] par_q;
    logic [DEPTH-1:0] par_d;
    logic             perr_q;
    logic             perr_d;

    always_comb begin
        par_d  = par_q;
        perr_d = ((^mem_q[adr]) != par_q[adr]);
        if (write_signal) begin
            par_d[adr] = ^data_in;
            perr_d     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            par_q  <= '0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram8x8_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ram8x8_sync : directed self-checking bench for ram8x8_sync               |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_ram8x8_sync;

    logic       clock;
    logic       reset;
    logic [2:0] adr;
    logic [7:0] data_in;
    logic       write_signal;
    logic [7:0] data_out;
`ifdef RAM_PARITY_EN
    logic       parity_err;
    logic [7:0] par_snap;
`endif

    int n_vec;
    int n_err;

    ram8x8_sync dut (
        .clock        (clock),
        .reset        (reset),
        .adr          (adr),
        .data_in      (data_in),
        .write_signal (write_signal),
`ifdef RAM_PARITY_EN
        .data_out     (data_out),
        .parity_err   (parity_err)
`else
        .data_out     (data_out)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp_v);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        reset        = 1'b0;
        adr          = a;
        data_in      = d;
        write_signal = 1'b1;
        step();
    endtask

    task automatic do_read(input logic [2:0] a);
        reset        = 1'b0;
        adr          = a;
        data_in      = 8'hC3;
        write_signal = 1'b0;
        step();
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        reset        = 1'b1;
        adr          = 3'd0;
        data_in      = 8'h00;
        write_signal = 1'b0;
        step();
        chk("reset_dout", data_out, 8'h00);

        do_read(3'd1); chk("rd1_after_reset", data_out, 8'h00);
        do_read(3'd0); chk("rd0_after_reset", data_out, 8'h00);

        do_write(3'd1, 8'h05); chk("wr1_through", data_out, 8'h05);
        do_read(3'd1);         chk("rd1_05", data_out, 8'h05);
        do_read(3'd0);         chk("rd0_still0", data_out, 8'h00);

        for (int i = 0; i < 8; i++) begin
            logic [7:0] v;
            v = 8'(8'h11 * (i + 1));
            do_write(3'(i), v);
            chk($sformatf("fill_wr%0d", i), data_out, v);
        end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] v;
            v = 8'(8'h11 * (i + 1));
            do_read(3'(i));
            chk($sformatf("fill_rd%0d", i), data_out, v);
        end

        do_write(3'd3, 8'hAA); chk("wr3_AA", data_out, 8'hAA);
        do_write(3'd3, 8'h55); chk("wr3_55", data_out, 8'h55);
        do_read(3'd3);         chk("rd3_last_wins", data_out, 8'h55);
        do_read(3'd4);         chk("rd4_untouched", data_out, 8'h55);

        do_write(3'd2, 8'h5A); chk("wr2_5A", data_out, 8'h5A);
        reset        = 1'b1;
        adr          = 3'd2;
        data_in      = 8'hFF;
        write_signal = 1'b1;
        step();
        chk("reset_with_write", data_out, 8'h00);
        do_read(3'd2); chk("rd2_cleared", data_out, 8'h00);
        do_read(3'd7); chk("rd7_cleared", data_out, 8'h00);

`ifdef RAM_PARITY_EN
        chk("perr_after_reset", {7'd0, parity_err}, 8'h00);
        do_write(3'd4, 8'h07); chk("perr_on_write", {7'd0, parity_err}, 8'h00);
        do_read(3'd4);
        chk("rd4_07", data_out, 8'h07);
        chk("perr_clean", {7'd0, parity_err}, 8'h00);
        par_snap = dut.par_q ^ 8'h10;
        force dut.par_q = par_snap;
        do_read(3'd4);
        chk("perr_flip", {7'd0, parity_err}, 8'h01);
        chk("rd4_flip_data", data_out, 8'h07);
        release dut.par_q;
        do_write(3'd4, 8'h07); chk("perr_rewrite", {7'd0, parity_err}, 8'h00);
        do_read(3'd4);         chk("perr_repaired", {7'd0, parity_err}, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
